stc0_readback: RTL and testbench

Bus-readable result collector for the stc0 datapath. Captures the biplex FFT output ports A and B into two independent FIFOs and serves them over a simple single-cycle read bus. It also exposes sticky status and a sample counter. It is the read-side counterpart of the write-side control/ingress path. It sits between the FFT egress and the host read interface.

---
 rtl/stc0_readback.sv | 148 ++++++++++++++
 tb/tb_stc0_readback.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stc0_readback.sv
// stc0 result collector: two independent sample FIFOs (FFT ports A/B) plus
// sticky status and an A-sample counter, served over a single-cycle read bus.

module stc0_readback_fifo #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  input  logic [W-1:0]  push_data,
  input  logic          pop_req,
  output logic [W-1:0]  head,
  output logic [AW:0]   level,
  output logic          push_acc,
  output logic          pop_acc,
  output logic          ovf_evt,
  output logic          und_evt
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic          full, empty;

  // level saturates at 2**AW, so its MSB alone marks full
  assign full     = level[AW];
  assign empty    = (level == '0);
  assign pop_acc  = pop_req && !empty;
  assign und_evt  = pop_req && empty;
  assign push_acc = push_valid && (!full || pop_acc);
  assign ovf_evt  = push_valid && !push_acc;
  assign head     = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_acc) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc)  rptr <= rptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module stc0_readback #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                    Clk,
  input  logic                    ARst_n,
  input  logic [2*DATA_WIDTH-1:0] AIngress,
  input  logic                    AIngressValid,
  input  logic [2*DATA_WIDTH-1:0] BIngress,
  input  logic                    BIngressValid,
  input  logic [23:2]             ReadAddr,
  input  logic                    ReadReq,
  output logic [31:0]             ReadData,
  output logic                    ReadDataValid
);
  localparam int W  = 2 * DATA_WIDTH;
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int NP = 2;  // port 0 = A, port 1 = B

  logic [NP-1:0][W-1:0]  in_data, head;
  logic [NP-1:0][AW:0]   level;
  logic [NP-1:0]         in_vld, pop_req, push_acc, pop_acc, ovf_evt, und_evt;
  logic [NP-1:0]         ovf, und;
  logic [31:0]           sample_cnt, status, rd_next;
  logic                  sel, rd_status;
  logic [2:0]            off;
  logic                  unused_sink;

  assign in_data[0] = AIngress;
  assign in_data[1] = BIngress;
  assign in_vld     = {BIngressValid, AIngressValid};

  assign sel       = ReadReq && (ReadAddr[23:20] == 4'h2);
  assign off       = ReadAddr[4:2];
  assign rd_status = sel && (off == 3'd2);

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign pop_req[p] = sel && (off == 3'(p));
    stc0_readback_fifo #(.W(W), .AW(AW)) u_fifo (
      .clk       (Clk),
      .rst_n     (ARst_n),
      .push_valid(in_vld[p]),
      .push_data (in_data[p]),
      .pop_req   (pop_req[p]),
      .head      (head[p]),
      .level     (level[p]),
      .push_acc  (push_acc[p]),
      .pop_acc   (pop_acc[p]),
      .ovf_evt   (ovf_evt[p]),
      .und_evt   (und_evt[p])
    );
  end

  // 8-bit level field; only a 256-deep FIFO can exceed it (full reads as 0)
  function automatic logic [7:0] lvl8(input logic [AW:0] l);
    logic [15:0] t;
    t = 16'(l);
    return t[7:0];
  endfunction

  assign status = {ovf[0], ovf[1], und[0], und[1], 12'b0,
                   lvl8(level[1]), lvl8(level[0])};

  always_comb begin
    rd_next = '0;
    if (sel) begin
      case (off)
        3'd0:    if (pop_acc[0]) rd_next = 32'(head[0]);
        3'd1:    if (pop_acc[1]) rd_next = 32'(head[1]);
        3'd2:    rd_next = status;
        3'd3:    rd_next = sample_cnt;
        default: rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ARst_n) begin
    if (!ARst_n) begin
      ovf           <= '0;
      und           <= '0;
      sample_cnt    <= '0;
      ReadData      <= '0;
      ReadDataValid <= 1'b0;
    end else begin
      // a same-cycle set event survives the clearing STATUS read
      ovf <= (rd_status ? '0 : ovf) | ovf_evt;
      und <= (rd_status ? '0 : und) | und_evt;
      if (push_acc[0]) sample_cnt <= sample_cnt + 32'd1;
      ReadDataValid <= ReadReq;
      if (ReadReq) ReadData <= rd_next;
    end
  end

  assign unused_sink = ^{ReadAddr[19:5], push_acc[1]};
endmodule

// File: tb/tb_stc0_readback.sv
// Randomized bench for stc0_readback: queue-based reference model, per-cycle
// compare process, plus literal expectations for the directed scenarios.

module tb_stc0_readback;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic              Clk, ARst_n;
  logic [2*DW-1:0]   AIngress, BIngress;
  logic              AIngressValid, BIngressValid;
  logic [23:2]       ReadAddr;
  logic              ReadReq;
  logic [31:0]       ReadData;
  logic              ReadDataValid;

  stc0_readback #(.DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(AW)) dut (
    .Clk(Clk), .ARst_n(ARst_n),
    .AIngress(AIngress), .AIngressValid(AIngressValid),
    .BIngress(BIngress), .BIngressValid(BIngressValid),
    .ReadAddr(ReadAddr), .ReadReq(ReadReq),
    .ReadData(ReadData), .ReadDataValid(ReadDataValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] qa[$], qb[$];
  bit          oa, ob, ua, ub;
  logic [31:0] sc;
  bit          pend_v, exp_v, chk_en;
  logic [31:0] pend_d, exp_d;

  function automatic logic [23:2] wa(input logic [23:0] b);
    return b[23:2];
  endfunction

  task automatic model_clear();
    qa.delete(); qb.delete();
    oa = 0; ob = 0; ua = 0; ub = 0; sc = 0;
  endtask

  // evaluate one clock edge on the model using the pre-edge state
  task automatic model_step(input bit av, input logic [31:0] ad, input bit bv,
                            input logic [31:0] bd, input bit rq, input logic [23:2] addr);
    int sa, sb;
    bit in_reg, popa, popb, eoa, eob, eua, eub;
    logic [2:0] off;
    logic [31:0] resp;
    sa = qa.size(); sb = qb.size();
    in_reg = rq && (addr[23:20] == 4'h2);
    off = addr[4:2];
    resp = 0; eoa = 0; eob = 0; eua = 0; eub = 0;
    popa = in_reg && off == 3'd0;
    popb = in_reg && off == 3'd1;
    if (popa) begin if (sa > 0) resp = qa.pop_front(); else eua = 1; end
    if (popb) begin if (sb > 0) resp = qb.pop_front(); else eub = 1; end
    if (in_reg && off == 3'd2) resp = {oa, ob, ua, ub, 12'b0, 8'(sb), 8'(sa)};
    if (in_reg && off == 3'd3) resp = sc;
    if (av) begin
      if (sa < DEPTH || (popa && sa > 0)) begin qa.push_back(ad); sc = sc + 1; end
      else eoa = 1;
    end
    if (bv) begin
      if (sb < DEPTH || (popb && sb > 0)) qb.push_back(bd);
      else eob = 1;
    end
    if (in_reg && off == 3'd2) begin oa = 0; ob = 0; ua = 0; ub = 0; end
    oa |= eoa; ob |= eob; ua |= eua; ub |= eub;
    pend_v = rq;
    pend_d = resp;
  endtask

  // drive one cycle; returns after the edge (+1) with expectations updated
  task automatic cyc(input bit av, input logic [31:0] ad, input bit bv,
                     input logic [31:0] bd, input bit rq, input logic [23:2] addr);
    AIngressValid = av; AIngress = ad;
    BIngressValid = bv; BIngress = bd;
    ReadReq = rq; ReadAddr = addr;
    model_step(av, ad, bv, bd, rq, addr);
    @(posedge Clk); #1;
    exp_v = pend_v;
    if (pend_v) exp_d = pend_d;
    AIngressValid = 0; BIngressValid = 0; ReadReq = 0;
  endtask

  task automatic rd(input logic [23:0] byte_addr, output logic [31:0] d);
    cyc(0, 0, 0, 0, 1, wa(byte_addr));
    d = ReadData;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0);
  endtask

  // reset asserted mid-cycle; outputs must drop without waiting for a clock
  task automatic do_reset();
    chk_en = 0;
    AIngressValid = 0; BIngressValid = 0; ReadReq = 0;
    #3 ARst_n = 1'b0;
    #1;
    check("rst_rdv", {31'b0, ReadDataValid}, 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    model_clear();
    exp_v = 0; exp_d = 0;
    @(posedge Clk); #2 ARst_n = 1'b1;
    @(posedge Clk); #1;
    chk_en = 1;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("rdv", {31'b0, ReadDataValid}, {31'b0, exp_v});
      check("rdata", ReadData, exp_d);
    end
  end

  initial begin
    logic [31:0] d;
    logic [23:2] a;
    int r, pa, pb, pr;
    ARst_n = 0; AIngress = 0; BIngress = 0; AIngressValid = 0; BIngressValid = 0;
    ReadAddr = '0; ReadReq = 0; chk_en = 0; exp_v = 0; exp_d = 0; pend_v = 0; pend_d = 0;
    model_clear();
    do_reset();

    rd(24'h200008, d); check("lit_status0", d, 32'h0);
    rd(24'h20000C, d); check("lit_cnt0", d, 32'h0);

    cyc(1, 32'h00010002, 0, 0, 0, '0);
    cyc(1, 32'h00030004, 0, 0, 0, '0);
    cyc(1, 32'h00050006, 0, 0, 0, '0);
    rd(24'h200000, d); check("lit_pop0", d, 32'h00010002);
    rd(24'h200000, d); check("lit_pop1", d, 32'h00030004);
    rd(24'h200000, d); check("lit_pop2", d, 32'h00050006);
    rd(24'h200008, d); check("lit_status1", d, 32'h0);

    do_reset();
    for (int i = 0; i <= 16; i++) cyc(1, i, 0, 0, 0, '0);
    rd(24'h200008, d); check("lit_ovf", d, 32'h80000010);
    rd(24'h200008, d); check("lit_ovf_clr", d, 32'h00000010);
    for (int i = 0; i < 16; i++) begin
      rd(24'h200000, d); check("lit_pop_seq", d, i);
    end
    rd(24'h20000C, d); check("lit_cnt16", d, 32'd16);

    rd(24'h200004, d); check("lit_undb", d, 32'h0);
    rd(24'h200008, d); check("lit_und_status", d, 32'h10000000);
    rd(24'h200008, d); check("lit_und_clr", d, 32'h0);

    for (int i = 0; i < 16; i++) cyc(1, 32'h100 + i, 0, 0, 0, '0);
    cyc(1, 32'h0000AAAA, 0, 0, 1, wa(24'h200000));
    check("lit_pushpop", ReadData, 32'h100);
    rd(24'h200008, d); check("lit_pushpop_status", d, 32'h00000010);
    for (int i = 0; i < 16; i++) rd(24'h200000, d);
    check("lit_last", d, 32'h0000AAAA);

    for (int i = 0; i < 5; i++) cyc(1, 32'h50 + i, 1, 32'h60 + i, 0, '0);
    cyc(0, 0, 0, 0, 1, wa(24'h200008));
    do_reset();
    rd(24'h200008, d); check("lit_rst_status", d, 32'h0);
    rd(24'h20000C, d); check("lit_rst_cnt", d, 32'h0);

    // random phases with varied push/read pressure to hit full and empty
    for (int ph = 0; ph < 4; ph++) begin
      pa = (ph == 1) ? 90 : (ph == 2) ? 20 : 50;
      pb = (ph == 3) ? 90 : 40;
      pr = (ph == 1) ? 30 : 70;
      for (int i = 0; i < 500; i++) begin
        r = $urandom_range(0, 9);
        a = 22'($urandom);
        a[23:20] = (r < 8) ? 4'h2 : 4'h5;
        a[4:2] = 3'(r);
        cyc($urandom_range(0, 99) < pa, $urandom, $urandom_range(0, 99) < pb, $urandom,
            $urandom_range(0, 99) < pr, a);
      end
    end
    idle(2);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
